l1in_counter_tmr: RTL
=====================

// Module: l1in_counter_tmr
// PURPOSE
//  Parametrised triple-modular-redundant (TMR) L1 trigger-ID counter for the readout-control path.
//  - Counts L1 triggers accepted while the L1 register is not full.
//  - Majority-votes three replicas every cycle and presents the trigger ID Gray-coded to the L1 register bank.
//  - Adds over the 4-bit generation: WIDTH/RESET_VAL, sync ECR clear, wrap and drop pulses, per-replica SEU
//    diagnosis, sticky error with clear, optional SEU event counter.
// PARAMETERS
//  WIDTH      4  counter/ID width in bits, legal range 2..16
//  RESET_VAL  0  binary value loaded by Reset and by Ecr, must be < 2**WIDTH
//  SEU_CNT_W  8  width of SeuCount; used only with L1IN_SEU_CNT_EN
// PORTS
//  Clk          in   1          rising-edge clock
//  Reset        in   1          asynchronous, active-high reset
//  L1           in   1          trigger strobe, 1 cycle per trigger
//  L1_Reg_Full  in   1          L1 register full; blocks counting
//  Ecr          in   1          synchronous event-counter reset
//  ErrClr       in   1          synchronous clear of ErrorSticky (and SeuCount)
//  L1In         out  WIDTH      Gray-coded voted count: Bin ^ (Bin >> 1)
//  L1Bin        out  WIDTH      binary voted count
//  Wrap         out  1          registered pulse: count stepped 2**WIDTH-1 -> 0
//  L1_Dropped   out  1          registered pulse: L1 rejected (full or Ecr)
//  Error        out  1          registered pulse: replica mismatch seen last cycle
//  ErrReplica   out  3          registered: bit i = replica i disagreed with vote
//  ErrorSticky  out  1          set by Error, held until ErrClr
//  SeuCount     out  SEU_CNT_W  mismatch-cycle count (L1IN_SEU_CNT_EN only)
// BEHAVIOUR
//  - Storage: three WIDTH-bit replicas R0..R2. Vote V = bitwise majority (R0&R1 | R1&R2 | R2&R0).
//  - L1Bin = V and L1In = Gray(V), both combinational from the replica flops.
//  - Next state, written identically into all replicas on each rising Clk:
//    - Ecr=1: RESET_VAL. Ecr takes priority over L1.
//    - Else L1 & !L1_Reg_Full: V + 1, mod 2**WIDTH; wraps silently.
//    - Else: V. A single upset is therefore scrubbed on the next edge.
//  - Latency: L1 accepted in cycle n -> L1In/L1Bin show the new ID in cycle n+1. No output changes
//    without an accepted L1 or Ecr.
//  - Wrap: 1 in cycle n+1 when the cycle-n increment took V from 2**WIDTH-1 to 0. Ecr never asserts Wrap.
//  - L1_Dropped: 1 in cycle n+1 when cycle n had L1=1 and (L1_Reg_Full=1 or Ecr=1).
//  - Mismatch M = !(R0==R1 && R1==R2), evaluated on the flops in cycle n.
//    - Error = M and ErrReplica[i] = (Ri != V), both registered in cycle n+1.
//    - Error is held in three flops and voted, as the counter is.
//    - Upset with no L1: Error is a 1-cycle pulse, because the replicas rewrite from V.
//  - Two replicas upset on the same bit: the vote follows the corrupted pair. This is not detectable.
//    Error still pulses; ErrReplica marks the healthy replica.
//  - ErrorSticky: set when Error=1, cleared when ErrClr=1. Set wins when both occur in the same cycle.
//  - Reset (async, any time including mid-trigger):
//    - R0..R2 = RESET_VAL, so L1In = Gray(RESET_VAL).
//    - Wrap, L1_Dropped, Error, ErrReplica, ErrorSticky and SeuCount = 0.
//    - An L1 coincident with Reset release is not required to count.
// CONFIGURATION
//  - L1IN_SEU_CNT_EN defined:
//    - SeuCount increments by 1 on each cycle with Error=1 and saturates at 2**SEU_CNT_W-1.
//    - ErrClr zeroes SeuCount; an increment and ErrClr in the same cycle give 0.
//  - L1IN_SEU_CNT_EN undefined:
//    - SeuCount is driven constant 0 and its counter logic is not synthesised.
//    - All other behaviour is identical.
// TESTING
//  1. WIDTH=4, RESET_VAL=0: Reset, then 5 L1 with full=0 -> L1Bin=5, L1In=4'b0111; Wrap, Error, L1_Dropped stay 0.
//  2. 16 L1 from 0 -> the 16th gives L1Bin=0 and Wrap=1 for one cycle.
//     L1In changes exactly one bit per step throughout.
//  3. L1_Reg_Full=1 with 3 L1 -> count unchanged, L1_Dropped pulses 3 times.
//     L1 and Ecr in the same cycle at count 9 -> L1Bin=RESET_VAL, L1_Dropped=1.
//  4. Force R1 bit2 flipped for 1 cycle at count 6:
//     - L1Bin stays 6.
//     - Next cycle: Error=1, ErrReplica=3'b010, ErrorSticky=1.
//     - Following cycle: Error=0, replicas equal.
//     - ErrClr -> ErrorSticky=0.
//  5. Force an upset on the same cycle as an accepted L1 at count 3 -> count reaches 4 in all replicas,
//     Error pulses once. With L1IN_SEU_CNT_EN: SeuCount=1; 300 forced upsets at SEU_CNT_W=8 -> 255.
//  6. Assert Reset mid-sequence at count 11 while Error=1 and ErrorSticky=1:
//     - Immediately: L1In = Gray(RESET_VAL) and every flag = 0.
//     - Re-run case 1 with WIDTH=10, RESET_VAL=1000: 30 L1 -> L1Bin=6, Wrap pulsed once.

Source files
------------

// File: rtl/l1in_counter_tmr.sv
// l1in_counter_tmr: triple-modular-redundant L1 trigger-ID counter.
// Counts L1 triggers accepted while the L1 register has room. The three
// replicas are majority-voted every cycle. The voted ID is written back into
// all three replicas, so a single upset is scrubbed on the next edge.
//
// Ports
//   Clk, Reset        rising-edge clock, asynchronous active-high reset
//   L1                trigger strobe, one cycle per trigger
//   L1_Reg_Full       L1 register full; a trigger seen while full is dropped
//   Ecr               synchronous event-counter reset to RESET_VAL
//   ErrClr            synchronous clear of ErrorSticky (and SeuCount)
//   L1In / L1Bin      Gray-coded / binary voted count (combinational from flops)
//   Wrap              pulse: count stepped from all-ones to zero
//   L1_Dropped        pulse: trigger rejected (full or Ecr)
//   Error             pulse: replica mismatch seen the previous cycle (voted)
//   ErrReplica        bit i set when replica i disagreed with the vote
//   ErrorSticky       set by a mismatch, held until ErrClr
//   SeuCount          saturating count of Error cycles
//
// Build option: when L1IN_SEU_CNT_EN is defined the SEU event counter is built.
// Otherwise SeuCount is tied to zero.
module l1in_counter_tmr #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned RESET_VAL = 0,
    parameter int unsigned SEU_CNT_W = 8
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 L1,
    input  logic                 L1_Reg_Full,
    input  logic                 Ecr,
    input  logic                 ErrClr,
    output logic [WIDTH-1:0]     L1In,
    output logic [WIDTH-1:0]     L1Bin,
    output logic                 Wrap,
    output logic                 L1_Dropped,
    output logic                 Error,
    output logic [2:0]           ErrReplica,
    output logic                 ErrorSticky,
    output logic [SEU_CNT_W-1:0] SeuCount
);

    localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] MAX_V = {WIDTH{1'b1}};

    logic [WIDTH-1:0] r0, r1, r2;
    logic [WIDTH-1:0] vote;
    logic [WIDTH-1:0] nxt;
    logic             e0, e1, e2;
    logic             mismatch;
    logic             accept;
    logic             wrap_nxt;
    logic             drop_nxt;
    logic [2:0]       err_rep_nxt;

    // Bitwise majority of the three replicas
    assign vote  = (r0 & r1) | (r1 & r2) | (r2 & r0);
    assign L1Bin = vote;
    assign L1In  = vote ^ (vote >> 1);

    assign mismatch    = (r0 != r1) || (r1 != r2);
    assign err_rep_nxt = {r2 != vote, r1 != vote, r0 != vote};

    // Ecr takes priority, so a trigger in the same cycle is dropped
    assign accept   = L1 && !L1_Reg_Full && !Ecr;
    assign drop_nxt = L1 && (L1_Reg_Full || Ecr);

    // Error is stored in three flops and voted, as the counter is
    assign Error = (e0 & e1) | (e1 & e2) | (e2 & e0);

    // Next count, written identically into every replica
    always_comb begin
        nxt      = vote;
        wrap_nxt = 1'b0;
        if (Ecr) begin
            nxt = RST_V;
        end else if (accept) begin
            nxt      = vote + WIDTH'(1);
            wrap_nxt = (vote == MAX_V);
        end
    end

    // Replica, flag and diagnosis registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r0          <= RST_V;
            r1          <= RST_V;
            r2          <= RST_V;
            e0          <= 1'b0;
            e1          <= 1'b0;
            e2          <= 1'b0;
            Wrap        <= 1'b0;
            L1_Dropped  <= 1'b0;
            ErrReplica  <= 3'b000;
            ErrorSticky <= 1'b0;
        end else begin
            r0          <= nxt;
            r1          <= nxt;
            r2          <= nxt;
            e0          <= mismatch;
            e1          <= mismatch;
            e2          <= mismatch;
            Wrap        <= wrap_nxt;
            L1_Dropped  <= drop_nxt;
            ErrReplica  <= err_rep_nxt;
            // Setting wins over a coincident clear
            ErrorSticky <= mismatch || (ErrorSticky && !ErrClr);
        end
    end

`ifdef L1IN_SEU_CNT_EN
    logic [SEU_CNT_W-1:0] seu_cnt;

    // Saturating count of cycles with Error asserted; a clear wins over an increment
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            seu_cnt <= '0;
        end else if (ErrClr) begin
            seu_cnt <= '0;
        end else if (Error && (seu_cnt != {SEU_CNT_W{1'b1}})) begin
            seu_cnt <= seu_cnt + SEU_CNT_W'(1);
        end
    end

    assign SeuCount = seu_cnt;
`else
    assign SeuCount = '0;
`endif

endmodule
